// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and the physical register tag type.
// Imported by free_list, map_table and the ROB so tag widths always agree.
package ooo_pkg;

    localparam int PR_NUM   = 64;
    localparam int AR_NUM   = 32;
    localparam int PR_W     = 6;
    localparam int FL_DEPTH = PR_NUM - AR_NUM;
    localparam int FL_PTR_W = $clog2(FL_DEPTH);

    typedef logic [PR_W-1:0] pr_tag_t;

endpackage

// File: rtl/circ_fifo_ptr.sv
// Head/tail/count bookkeeping for a circular buffer; starts full after reset.
// Latency: pointer and count updates land on the clock edge after push/pop.
// Backpressure: a push into a full buffer without a pop is dropped and flags a sticky overflow.
module circ_fifo_ptr #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        pop_ok     = pop & ~empty;
        // A pop in the same cycle frees the slot the push lands in.
        push_ok    = push & (~full | pop_ok);
        head_d     = pop_ok  ? ptr_inc(head_q) : head_q;
        tail_d     = push_ok ? ptr_inc(tail_q) : tail_q;
        count_d    = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        overflow_d = overflow_q | (push & ~push_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = head_q;
    assign tail     = tail_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/free_list.sv
// Free physical register tag FIFO feeding rename; reclaims tags at commit and recovery walk.
// Latency: zero-cycle show-ahead read of the head tag; pushes become visible the next cycle.
// Backpressure: free_empty stalls dispatch; pushes into a full list are dropped and set overflow.
module free_list
    import ooo_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            RegDest,
    input  logic            hazard_stall,
    input  logic            recover,
    input  logic            RegDest_ROB,
    input  pr_tag_t         p_rd_flush,
    input  logic            commit,
    input  logic            RegDest_commit,
    input  pr_tag_t         PR_old_commit,
    output pr_tag_t         p_rd_new,
    output logic            free_empty,
    output logic [PR_W-1:0] free_cnt,
    output logic            overflow
);

    pr_tag_t               mem_q [FL_DEPTH];
    pr_tag_t               mem_d [FL_DEPTH];
    pr_tag_t               push_tag;
    logic                  pop, push_vld, wr_en, full;
    logic [FL_PTR_W-1:0]   head, tail;

    always_comb begin
        pop = RegDest & ~hazard_stall & ~recover & ~free_empty;
        // Single write port: the recovery walk owns it, so a colliding commit is dropped.
        if (recover) begin
            push_vld = RegDest_ROB;
            push_tag = p_rd_flush;
        end else begin
            push_vld = commit & RegDest_commit;
            push_tag = PR_old_commit;
        end
        wr_en = push_vld & (~full | pop);
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[tail] = push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= pr_tag_t'(AR_NUM + i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    circ_fifo_ptr #(
        .DEPTH (FL_DEPTH),
        .PTR_W (FL_PTR_W),
        .CNT_W (PR_W)
    ) u_ptr (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push_vld),
        .pop      (pop),
        .head     (head),
        .tail     (tail),
        .count    (free_cnt),
        .full     (full),
        .empty    (free_empty),
        .overflow (overflow)
    );

    assign p_rd_new = mem_q[head];

    a_no_recover_commit: assert property (@(posedge clk) disable iff (!rst) !(recover && commit));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table, hand-written corner sequences and a randomized run
// checked against a queue-based model of the free tag list.
module tb_free_list;
    import ooo_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegDest, hazard_stall, recover, RegDest_ROB, commit, RegDest_commit;
    pr_tag_t         p_rd_flush, PR_old_commit, p_rd_new;
    logic            free_empty, overflow;
    logic [PR_W-1:0] free_cnt;

    always #5 clk = ~clk;

    free_list dut (
        .clk            (clk),
        .rst            (rst),
        .RegDest        (RegDest),
        .hazard_stall   (hazard_stall),
        .recover        (recover),
        .RegDest_ROB    (RegDest_ROB),
        .p_rd_flush     (p_rd_flush),
        .commit         (commit),
        .RegDest_commit (RegDest_commit),
        .PR_old_commit  (PR_old_commit),
        .p_rd_new       (p_rd_new),
        .free_empty     (free_empty),
        .free_cnt       (free_cnt),
        .overflow       (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mq[$];
    bit m_ovf;

    typedef struct {
        logic       rd, hs, rec, rdrob;
        logic [5:0] flush;
        logic       com, rdcom;
        logic [5:0] old;
        int         exp_tag;
        int         exp_cnt;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < FL_DEPTH; i++) mq.push_back(AR_NUM + i);
        m_ovf = 1'b0;
    endtask

    task automatic check_model(input string nm);
        chk({nm, "_cnt"}, int'(free_cnt), mq.size());
        chk({nm, "_empty"}, int'(free_empty), (mq.size() == 0) ? 1 : 0);
        chk({nm, "_ovf"}, int'(overflow), int'(m_ovf));
        if (mq.size() > 0) chk({nm, "_tag"}, int'(p_rd_new), mq[0]);
    endtask

    // Free list rules applied to the inputs present for the coming edge.
    task automatic model_step();
        bit pop, push;
        int ptag;
        pop = RegDest && !hazard_stall && !recover && (mq.size() > 0);
        if (recover) begin
            push = RegDest_ROB;
            ptag = int'(p_rd_flush);
        end else begin
            push = commit && RegDest_commit;
            ptag = int'(PR_old_commit);
        end
        if (push && mq.size() == FL_DEPTH && !pop) begin
            m_ovf = 1'b1;
            push  = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(ptag);
    endtask

    task automatic drive(input logic rd, input logic hs, input logic rec, input logic rdrob,
                         input logic [5:0] flush, input logic com, input logic rdcom,
                         input logic [5:0] old);
        @(negedge clk);
        RegDest        = rd;
        hazard_stall   = hs;
        recover        = rec;
        RegDest_ROB    = rdrob;
        p_rd_flush     = flush;
        commit         = com;
        RegDest_commit = rdcom;
        PR_old_commit  = old;
        #1;
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
    endtask

    task automatic cyc(input string nm, input logic rd, input logic com, input logic [5:0] old);
        drive(rd, 1'b0, 1'b0, 1'b0, 6'h0, com, com, old);
        check_model(nm);
        finish_cycle();
    endtask

    initial begin
        // rd hs rec rdrob flush com rdcom old | tag cnt (observed before the edge)
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h20, 32};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h20, 32};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h20, 32};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h20, 32};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h21, 31};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h22, 30};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h23, 29};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 6'h03, 'h23, 29};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h24, 29};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'h22, 1'b0, 1'b0, 6'h00, 'h24, 29};
        vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h15, 1'b0, 1'b0, 6'h00, 'h24, 30};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h24, 30};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 6'h11, 'h24, 30};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 'h24, 30};

        {RegDest, hazard_stall, recover, RegDest_ROB, commit, RegDest_commit} = '0;
        p_rd_flush    = '0;
        PR_old_commit = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rd, vt[i].hs, vt[i].rec, vt[i].rdrob, vt[i].flush,
                  vt[i].com, vt[i].rdcom, vt[i].old);
            chk($sformatf("vec%0d_tag", i), int'(p_rd_new), vt[i].exp_tag);
            chk($sformatf("vec%0d_cnt", i), int'(free_cnt), vt[i].exp_cnt);
            check_model($sformatf("vec%0d", i));
            finish_cycle();
        end

        // Drain: 0x24..0x3F, then the committed 0x03, then the recovered 0x22.
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0);
            chk("drain_tag", int'(p_rd_new), (i < 28) ? ('h24 + i) : ((i == 28) ? 'h03 : 'h22));
            check_model("drain");
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0);
            chk("empty_flag", int'(free_empty), 1);
            chk("empty_cnt", int'(free_cnt), 0);
            finish_cycle();
        end
        // Push into an empty list alongside a request: no bypass to p_rd_new.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 1'b1, 1'b1, 6'h05);
        chk("nobypass_empty", int'(free_empty), 1);
        finish_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0);
        chk("refill_empty", int'(free_empty), 0);
        chk("refill_tag", int'(p_rd_new), 'h05);
        check_model("refill");
        finish_cycle();

        for (int i = 0; i < 31; i++) cyc("fill", 1'b0, 1'b1, 6'(8 + i));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b1, 1'b1, 6'h07);
        chk("full_cnt", int'(free_cnt), 32);
        chk("full_ovf_pre", int'(overflow), 0);
        finish_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0);
            chk("ovf_sticky", int'(overflow), 1);
            chk("ovf_cnt", int'(free_cnt), 32);
            finish_cycle();
        end
        cyc("full_push_pop", 1'b1, 1'b1, 6'h09);
        cyc("after_push_pop", 1'b0, 1'b0, 6'h0);

        // Async reset pulse between edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_cnt", int'(free_cnt), 32);
        chk("arst_tag", int'(p_rd_new), 'h20);
        #1 rst = 1'b1;
        @(posedge clk);
        model_step();

        // Random traffic: pop-heavy, balanced, then push-heavy phases.
        for (int c = 0; c < 3000; c++) begin
            int  p_pop, p_push;
            logic rec;
            p_pop  = (c < 1000) ? 85 : ((c < 2000) ? 50 : 20);
            p_push = (c < 1000) ? 25 : ((c < 2000) ? 50 : 85);
            rec    = ($urandom_range(99) < 15);
            drive($urandom_range(99) < p_pop, $urandom_range(99) < 20, rec,
                  $urandom_range(99) < p_push, 6'($urandom),
                  !rec && ($urandom_range(99) < 90), $urandom_range(99) < p_push, 6'($urandom));
            check_model("rand");
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
